// File: rtl/datapath_pkg.sv
// datapath_pkg
//   Constants shared across the RISC datapath: the fixed register indices
//   used by the destination multiplexer and control unit, the program
//   counter step, and the default register-file geometry.
package datapath_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

    // Fixed register roles
    localparam logic [3:0] REG_LR = 4'hE;  // link register
    localparam logic [3:0] REG_PC = 4'hF;  // program counter

    // Byte increment applied to the PC each instruction
    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/reg_cell.sv
// reg_cell
//   One register of the register file: synchronous active-high reset,
//   load enable, otherwise holds.
// Ports
//   clk    rising-edge clock
//   reset  synchronous active-high reset (clears q, overrides load)
//   load   capture d at the next edge
//   d      next value
//   q      stored value
module reg_cell
    import datapath_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// register_file
//   General register file for the RISC datapath: 2**ADDR_WIDTH registers,
//   three combinational read ports with write-through bypass, one
//   synchronous write port, and a PC increment path on the top register
//   (R15 at the default width). R14 is the link register.
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset, clears every register
//   write_enable   commit write_data to write_addr at the next edge
//   write_addr     destination index
//   write_data     value to write
//   pc_inc_enable  add PC_STEP to the PC register at the next edge
//   read_addr_a/b/c  read indices
//   read_data_a/b/c  read values (bypassed from write_data on a match)
//   pc_out         stored PC register contents, never bypassed
module register_file
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  pc_inc_enable,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    input  logic [ADDR_WIDTH-1:0] read_addr_c,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic [DATA_WIDTH-1:0] read_data_c,
    output logic [DATA_WIDTH-1:0] pc_out
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    // The PC is the highest index; equals REG_PC at the default width.
    localparam logic [ADDR_WIDTH-1:0] PC_IDX = '1;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Ordinary registers R0 .. R(N-2)
    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_gpr
        logic load;
        assign load = write_enable && (write_addr == ADDR_WIDTH'(i));

        reg_cell #(.WIDTH(DATA_WIDTH)) u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .d     (write_data),
            .q     (regs[i])
        );
    end

    // PC register: an explicit write takes priority over the increment.
    logic                  pc_write;
    logic                  pc_load;
    logic [DATA_WIDTH-1:0] pc_next;

    assign pc_write = write_enable && (write_addr == PC_IDX);
    assign pc_load  = pc_write || pc_inc_enable;
    assign pc_next  = pc_write ? write_data
                               : regs[PC_IDX] + DATA_WIDTH'(PC_STEP);

    reg_cell #(.WIDTH(DATA_WIDTH)) u_pc_cell (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_next),
        .q     (regs[PC_IDX])
    );

    // Read ports with write-through bypass. The bypass is independent of
    // reset, and a pending PC increment is never forwarded.
    assign read_data_a = (write_enable && (read_addr_a == write_addr))
                         ? write_data : regs[read_addr_a];
    assign read_data_b = (write_enable && (read_addr_b == write_addr))
                         ? write_data : regs[read_addr_b];
    assign read_data_c = (write_enable && (read_addr_c == write_addr))
                         ? write_data : regs[read_addr_c];

    assign pc_out = regs[PC_IDX];

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Self-checking bench for register_file: directed scenarios followed by
//   randomized traffic, all compared against an array-based reference model.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_enable = 1'b0;
    logic [3:0]  write_addr = '0;
    logic [31:0] write_data = '0;
    logic        pc_inc_enable = 1'b0;
    logic [3:0]  read_addr_a = '0;
    logic [3:0]  read_addr_b = '0;
    logic [3:0]  read_addr_c = '0;
    logic [31:0] read_data_a;
    logic [31:0] read_data_b;
    logic [31:0] read_data_c;
    logic [31:0] pc_out;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    logic [31:0] model [16];

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .pc_inc_enable (pc_inc_enable),
        .read_addr_a   (read_addr_a),
        .read_addr_b   (read_addr_b),
        .read_addr_c   (read_addr_c),
        .read_data_a   (read_data_a),
        .read_data_b   (read_data_b),
        .read_data_c   (read_data_c),
        .pc_out        (pc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        if (write_enable && addr == write_addr) return write_data;
        return model[addr];
    endfunction

    task automatic drive(input logic rst, input logic we, input logic [3:0] wa,
                         input logic [31:0] wd, input logic inc,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
        reset = rst;
        write_enable = we;
        write_addr = wa;
        write_data = wd;
        pc_inc_enable = inc;
        read_addr_a = ra;
        read_addr_b = rb;
        read_addr_c = rc;
        #1;
    endtask

    task automatic check_model();
        check("rd_a", read_data_a, model_read(read_addr_a));
        check("rd_b", read_data_b, model_read(read_addr_b));
        check("rd_c", read_data_c, model_read(read_addr_c));
        check("pc", pc_out, model[15]);
    endtask

    // Advance one edge and apply the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) model[i] = '0;
        end else begin
            if (pc_inc_enable) model[15] = model[15] + 32'd4;
            if (write_enable) model[write_addr] = write_data;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;
        @(posedge clk);
        #1;

        // Reset, then read all indices
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 0, 4'(i), 4'(15 - i), 4'(i));
            check("rst_rd_a", read_data_a, 32'h0);
            check_model();
            tick();
        end

        // Write then read
        drive(0, 1, 4'd3, 32'hDEAD_BEEF, 0, 4'd3, 4'd4, 4'd0);
        tick();
        drive(0, 0, 0, 0, 0, 4'd3, 4'd4, 4'd3);
        check("wr_rd_a", read_data_a, 32'hDEAD_BEEF);
        check("wr_rd_b", read_data_b, 32'h0);
        check_model();
        tick();

        // Bypass on all three ports
        drive(0, 1, 4'd7, 32'h1234, 0, 4'd7, 4'd7, 4'd7);
        check("byp_a", read_data_a, 32'h1234);
        check("byp_b", read_data_b, 32'h1234);
        check("byp_c", read_data_c, 32'h1234);
        check_model();
        tick();

        // PC increment and wrap
        drive(0, 1, 4'hF, 32'hFFFF_FFF8, 0, 4'hF, 0, 0);
        check("pc_byp_a", read_data_a, 32'hFFFF_FFF8);
        tick();
        drive(0, 0, 0, 0, 1, 4'hF, 0, 0);
        check("pc_pre", pc_out, 32'hFFFF_FFF8);
        check("pc_nofwd", read_data_a, 32'hFFFF_FFF8);
        tick();
        check("pc_inc1", pc_out, 32'hFFFF_FFFC);
        tick();
        check("pc_wrap", pc_out, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Conflict: write to PC wins over increment
        drive(0, 1, 4'hF, 32'd8, 0, 0, 0, 0);
        tick();
        drive(0, 1, 4'hF, 32'h100, 1, 0, 0, 0);
        tick();
        check("conf_pc", pc_out, 32'h100);

        // Conflict with LR: both take effect
        drive(0, 1, 4'hF, 32'd8, 0, 0, 0, 0);
        tick();
        drive(0, 1, 4'hE, 32'h100, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 4'hE, 4'hF, 4'hE);
        check("conf_lr", read_data_a, 32'h100);
        check("conf_pc12", pc_out, 32'd12);
        check("conf_rd_pc", read_data_b, 32'd12);
        tick();

        // Reset mid-operation; bypass still active during reset
        drive(0, 1, 4'd5, 32'hAA, 0, 0, 0, 0);
        tick();
        drive(1, 1, 4'd5, 32'hFF, 1, 4'd5, 4'd6, 4'd5);
        check("rst_byp", read_data_a, 32'hFF);
        check_model();
        tick();
        drive(0, 0, 0, 0, 0, 4'd5, 4'd3, 4'd7);
        check("rst_r5", read_data_a, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check_model();
        tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [3:0] wa;
            wa = ($urandom_range(0, 3) == 0) ? 4'(14 + $urandom_range(0, 1)) : 4'($urandom);
            drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, wa, $urandom,
                  $urandom_range(0, 2) == 0,
                  ($urandom_range(0, 2) == 0) ? wa : 4'($urandom),
                  4'($urandom), ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom));
            check_model();
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
